// File: rtl/bank_rr_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bank_req_if / bank_phy_if                                              |
// | Requester-side and RAM-side buses of the bank round-robin arbiter.     |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+

interface bank_req_if #(
  parameter int NUM_SLOTS = 4,
  parameter int DATA_W    = 64
);
  logic [NUM_SLOTS-1:0]             req_valid;
  logic [NUM_SLOTS-1:0]             req_rw;
  logic [NUM_SLOTS-1:0][4:0]        req_mask;
  logic [NUM_SLOTS-1:0][8:0]        req_addr;
  logic [NUM_SLOTS-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_SLOTS-1:0]             req_lock;
  logic [NUM_SLOTS-1:0]             req_ready;
  logic [NUM_SLOTS-1:0]             rsp_rvalid;
  logic [DATA_W-1:0]                rsp_rdata;

  modport master (
    output req_valid, req_rw, req_mask, req_addr, req_wdata, req_lock,
    input  req_ready, rsp_rvalid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_rw, req_mask, req_addr, req_wdata, req_lock,
    output req_ready, rsp_rvalid, rsp_rdata
  );
endinterface

interface bank_phy_if #(
  parameter int DATA_W = 64
);
  logic              phy_valid;
  logic              phy_rw;
  logic [4:0]        phy_mask;
  logic [8:0]        phy_addr;
  logic [DATA_W-1:0] phy_wdata;
  logic              phy_ready;
  logic              phy_rvalid;
  logic [DATA_W-1:0] phy_rdata;

  modport master (
    output phy_valid, phy_rw, phy_mask, phy_addr, phy_wdata,
    input  phy_ready, phy_rvalid, phy_rdata
  );

  modport slave (
    input  phy_valid, phy_rw, phy_mask, phy_addr, phy_wdata,
    output phy_ready, phy_rvalid, phy_rdata
  );
endinterface

`default_nettype wire

// File: rtl/bank_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bank_rr_arbiter                                                        |
// | Round-robin arbiter for one bank RAM port with in-order read-return   |
// | routing via a source-slot tag FIFO. Optional grant lock: define        |
// | BANK_ARB_LOCK_EN.                                                      |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+

module bank_rr_arbiter #(
  parameter int NUM_SLOTS = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_RD    = 4
) (
  input  wire logic   clk,
  input  wire logic   rstn,
  bank_req_if.slave   req,
  bank_phy_if.master  phy,
  output logic        err_orphan
);

  localparam int c_slot_w  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int c_fifo_aw = (MAX_RD > 1) ? $clog2(MAX_RD) : 1;
  localparam int c_cnt_w   = $clog2(MAX_RD + 1);

  localparam logic [c_cnt_w-1:0]   c_cnt_full  = c_cnt_w'(MAX_RD);
  localparam logic [c_slot_w-1:0]  c_last_slot = c_slot_w'(NUM_SLOTS - 1);
  localparam logic [c_fifo_aw-1:0] c_last_fifo = c_fifo_aw'(MAX_RD - 1);

  logic [c_slot_w-1:0]  r_rr_ptr;
  logic [c_cnt_w-1:0]   r_rd_cnt;
  logic [c_fifo_aw-1:0] r_wr_ptr;
  logic [c_fifo_aw-1:0] r_rd_ptr;
  logic [c_slot_w-1:0]  r_tag_mem [MAX_RD];

  logic                 r_phy_valid;
  logic                 r_phy_rw;
  logic [4:0]           r_phy_mask;
  logic [8:0]           r_phy_addr;
  logic [DATA_W-1:0]    r_phy_wdata;
  logic                 r_err_orphan;

  logic [NUM_SLOTS-1:0] w_elig;
  logic                 w_rr_found;
  logic [c_slot_w-1:0]  w_rr_winner;
  logic                 w_lock_win;
  logic                 w_found;
  logic [c_slot_w-1:0]  w_winner;
  logic                 w_free;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_orphan;
  logic [c_slot_w-1:0]  w_next_ptr;
  logic [NUM_SLOTS-1:0] w_grant;
  logic [NUM_SLOTS-1:0] w_rsp_rvalid;

  // A read is held back while the tag FIFO is full (registered count).
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_elig[i] = req.req_valid[i] && (req.req_rw[i] || (r_rd_cnt != c_cnt_full));
    end
  end

  always_comb begin
    int idx;
    w_rr_found  = 1'b0;
    w_rr_winner = '0;
    idx         = 0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_SLOTS;
      if (!w_rr_found && w_elig[idx]) begin
        w_rr_found  = 1'b1;
        w_rr_winner = c_slot_w'(idx);
      end
    end
  end

`ifdef BANK_ARB_LOCK_EN
  logic [c_slot_w-1:0] r_last_slot;
  logic                r_last_valid;

  // Lock only wins when the locked slot is itself eligible.
  always_comb begin
    w_lock_win = r_last_valid && req.req_lock[r_last_slot] && w_elig[r_last_slot];
    w_found    = w_rr_found || w_lock_win;
    w_winner   = w_lock_win ? r_last_slot : w_rr_winner;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last_slot  <= '0;
      r_last_valid <= 1'b0;
    end else if (w_accept) begin
      r_last_slot  <= w_winner;
      r_last_valid <= 1'b1;
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^req.req_lock;

  always_comb begin
    w_lock_win = 1'b0;
    w_found    = w_rr_found;
    w_winner   = w_rr_winner;
  end
`endif

  always_comb begin
    w_free   = !r_phy_valid || phy.phy_ready;
    w_accept = w_found && w_free && rstn;
    w_push   = w_accept && !req.req_rw[w_winner];
    w_pop    = phy.phy_rvalid && (r_rd_cnt != '0) && rstn;
    w_orphan = phy.phy_rvalid && (r_rd_cnt == '0);

    if (w_lock_win) begin
      w_next_ptr = r_rr_ptr;
    end else if (w_winner == c_last_slot) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = w_winner + 1'b1;
    end

    w_grant = '0;
    if (w_accept) begin
      w_grant[w_winner] = 1'b1;
    end

    w_rsp_rvalid = '0;
    if (w_pop) begin
      w_rsp_rvalid[r_tag_mem[r_rd_ptr]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_phy_valid <= 1'b0;
      r_phy_rw    <= 1'b0;
      r_phy_mask  <= '0;
      r_phy_addr  <= '0;
      r_phy_wdata <= '0;
      r_rr_ptr    <= '0;
    end else if (w_accept) begin
      r_phy_valid <= 1'b1;
      r_phy_rw    <= req.req_rw[w_winner];
      r_phy_mask  <= req.req_mask[w_winner];
      r_phy_addr  <= req.req_addr[w_winner];
      r_phy_wdata <= req.req_wdata[w_winner];
      r_rr_ptr    <= w_next_ptr;
    end else if (r_phy_valid && phy.phy_ready) begin
      r_phy_valid <= 1'b0;
    end
  end

  // Tag FIFO bookkeeping; a push at full cannot occur since full reads are ineligible.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_rd_cnt     <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_last_fifo) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_last_fifo) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_rd_cnt <= r_rd_cnt + 1'b1;
        2'b01:   r_rd_cnt <= r_rd_cnt - 1'b1;
        default: r_rd_cnt <= r_rd_cnt;
      endcase
      if (w_orphan) begin
        r_err_orphan <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= w_winner;
    end
  end

  assign req.req_ready  = w_grant;
  assign req.rsp_rvalid = w_rsp_rvalid;
  assign req.rsp_rdata  = phy.phy_rdata;

  assign phy.phy_valid  = r_phy_valid;
  assign phy.phy_rw     = r_phy_rw;
  assign phy.phy_mask   = r_phy_mask;
  assign phy.phy_addr   = r_phy_addr;
  assign phy.phy_wdata  = r_phy_wdata;

  assign err_orphan     = r_err_orphan;

endmodule

`default_nettype wire

// File: tb/tb_bank_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_bank_rr_arbiter                                                     |
// | Directed self-checking bench for bank_rr_arbiter.                      |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+

module tb_bank_rr_arbiter;

  localparam int NUM_SLOTS = 4;
  localparam int DATA_W    = 64;
  localparam int MAX_RD    = 4;

  logic clk;
  logic rstn;
  logic err_orphan;

  int n_checks = 0;
  int n_fail   = 0;

  bank_req_if #(.NUM_SLOTS(NUM_SLOTS), .DATA_W(DATA_W)) rq ();
  bank_phy_if #(.DATA_W(DATA_W)) ph ();

  bank_rr_arbiter #(
    .NUM_SLOTS (NUM_SLOTS),
    .DATA_W    (DATA_W),
    .MAX_RD    (MAX_RD)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (rq),
    .phy        (ph),
    .err_orphan (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rstn          = 1'b0;
    rq.req_valid  = 4'hF;
    rq.req_rw     = '0;
    rq.req_lock   = '0;
    rq.req_mask   = '0;
    rq.req_addr   = '0;
    rq.req_wdata  = '0;
    ph.phy_ready  = 1'b1;
    ph.phy_rvalid = 1'b1;
    ph.phy_rdata  = '0;

    // Reset state
    #1;
    chk("rst_ready",   rq.req_ready,  0);
    chk("rst_rvalid",  rq.rsp_rvalid, 0);
    chk("rst_pvalid",  ph.phy_valid,  0);
    chk("rst_paddr",   ph.phy_addr,   0);
    chk("rst_pwdata",  ph.phy_wdata,  0);
    chk("rst_orphan",  err_orphan,    0);
    tick();
    tick();
    chk("rst_orphan2", err_orphan,    0);
    ph.phy_rvalid = 1'b0;
    rq.req_valid  = '0;
    rstn          = 1'b1;

    // Round-robin with all slots writing
    for (int i = 0; i < NUM_SLOTS; i++) begin
      rq.req_mask[i]  = 5'(5'h10 | i);
      rq.req_addr[i]  = 9'(9'h040 + i);
      rq.req_wdata[i] = 64'(64'hD000 + i);
    end
    rq.req_rw    = 4'hF;
    rq.req_valid = 4'hF;
    #1;
    chk("rr0_ready",  rq.req_ready, 4'b0001);
    chk("rr0_pvalid", ph.phy_valid, 0);
    tick(); #1;
    chk("rr1_ready",  rq.req_ready, 4'b0010);
    chk("rr1_pvalid", ph.phy_valid, 1);
    chk("rr1_paddr",  ph.phy_addr,  9'h040);
    chk("rr1_pmask",  ph.phy_mask,  5'h10);
    chk("rr1_pwdata", ph.phy_wdata, 64'hD000);
    chk("rr1_prw",    ph.phy_rw,    1);
    tick(); #1;
    chk("rr2_ready",  rq.req_ready, 4'b0100);
    chk("rr2_paddr",  ph.phy_addr,  9'h041);
    tick(); #1;
    chk("rr3_ready",  rq.req_ready, 4'b1000);
    chk("rr3_paddr",  ph.phy_addr,  9'h042);
    chk("rr3_pwdata", ph.phy_wdata, 64'hD002);
    tick(); #1;
    chk("rr4_ready",  rq.req_ready, 4'b0001);
    chk("rr4_paddr",  ph.phy_addr,  9'h043);
    chk("rr4_pmask",  ph.phy_mask,  5'h13);
    tick();

    // Backpressure for three cycles
    ph.phy_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) tick();
      #1;
      chk("bp_ready",  rq.req_ready, 4'b0000);
      chk("bp_pvalid", ph.phy_valid, 1);
      chk("bp_paddr",  ph.phy_addr,  9'h040);
      chk("bp_pwdata", ph.phy_wdata, 64'hD000);
    end
    tick();
    ph.phy_ready = 1'b1;
    #1;
    chk("bp_rel_ready", rq.req_ready, 4'b0010);
    chk("bp_rel_paddr", ph.phy_addr,  9'h040);
    tick();
    rq.req_valid = '0;
    #1;
    chk("bp_next_paddr", ph.phy_addr,  9'h041);
    chk("bp_next_valid", ph.phy_valid, 1);
    tick(); #1;
    chk("drain_valid", ph.phy_valid, 0);

    // Read routing: slot 2 then slot 0
    rq.req_rw      = '0;
    rq.req_addr[2] = 9'h010;
    rq.req_addr[0] = 9'h020;
    rq.req_valid   = 4'b0100;
    #1;
    chk("rd_s2_ready", rq.req_ready, 4'b0100);
    tick();
    rq.req_valid = 4'b0001;
    #1;
    chk("rd_s0_ready", rq.req_ready, 4'b0001);
    chk("rd_s2_paddr", ph.phy_addr,  9'h010);
    chk("rd_s2_prw",   ph.phy_rw,    0);
    tick();
    rq.req_valid  = '0;
    ph.phy_rvalid = 1'b1;
    ph.phy_rdata  = 64'hAA;
    #1;
    chk("ret_aa_valid", rq.rsp_rvalid, 4'b0100);
    chk("ret_aa_data",  rq.rsp_rdata,  64'hAA);
    chk("rd_s0_paddr",  ph.phy_addr,   9'h020);
    tick();
    ph.phy_rdata = 64'hBB;
    #1;
    chk("ret_bb_valid", rq.rsp_rvalid, 4'b0001);
    chk("ret_bb_data",  rq.rsp_rdata,  64'hBB);
    tick();
    ph.phy_rvalid = 1'b0;
    #1;
    chk("ret_idle", rq.rsp_rvalid, 4'b0000);

    // Outstanding read limit (pointer now at slot 1)
    for (int i = 0; i < NUM_SLOTS; i++) rq.req_addr[i] = 9'(9'h080 + i);
    rq.req_valid = 4'hF;
    #1;
    chk("lim_r1", rq.req_ready, 4'b0010);
    tick(); #1;
    chk("lim_r2", rq.req_ready, 4'b0100);
    tick(); #1;
    chk("lim_r3", rq.req_ready, 4'b1000);
    tick(); #1;
    chk("lim_r4", rq.req_ready, 4'b0001);
    tick(); #1;
    chk("lim_full", rq.req_ready, 4'b0000);
    tick();
    ph.phy_rvalid = 1'b1;
    ph.phy_rdata  = 64'h11;
    #1;
    chk("lim_pop_rsp",   rq.rsp_rvalid, 4'b0010);
    chk("lim_pop_ready", rq.req_ready,  4'b0000);
    tick();
    ph.phy_rvalid = 1'b0;
    #1;
    chk("lim_r5", rq.req_ready, 4'b0010);
    tick();
    rq.req_valid  = '0;
    ph.phy_rvalid = 1'b1;
    #1; chk("lim_ret_s2", rq.rsp_rvalid, 4'b0100);
    tick(); #1; chk("lim_ret_s3", rq.rsp_rvalid, 4'b1000);
    tick(); #1; chk("lim_ret_s0", rq.rsp_rvalid, 4'b0001);
    tick(); #1; chk("lim_ret_s1", rq.rsp_rvalid, 4'b0010);
    tick();

    // Orphan return (FIFO empty now)
    #1;
    chk("orph_rsp",    rq.rsp_rvalid, 4'b0000);
    chk("orph_before", err_orphan,    0);
    tick();
    ph.phy_rvalid = 1'b0;
    #1;
    chk("orph_set", err_orphan, 1);
    tick();
    tick();
    chk("orph_sticky", err_orphan, 1);

    // Reset mid-operation loses the outstanding tag
    rq.req_valid = 4'b0001;
    #1;
    chk("mid_ready", rq.req_ready, 4'b0001);
    tick();
    rq.req_valid = '0;
    rstn = 1'b0;
    #1;
    chk("mid_orph_clr", err_orphan,   0);
    chk("mid_pvalid",   ph.phy_valid, 0);
    tick();
    rstn          = 1'b1;
    ph.phy_rvalid = 1'b1;
    #1;
    chk("mid_ret_rsp", rq.rsp_rvalid, 4'b0000);
    tick();
    ph.phy_rvalid = 1'b0;
    #1;
    chk("mid_ret_orph", err_orphan, 1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;

    // Lock: slot 1 locked, slot 0 competing
    rq.req_rw    = 4'hF;
    rq.req_valid = 4'b0011;
    rq.req_lock  = 4'b0010;
    #1;
    chk("lk_c1", rq.req_ready, 4'b0001);
    tick(); #1;
    chk("lk_c2", rq.req_ready, 4'b0010);
    tick(); #1;
`ifdef BANK_ARB_LOCK_EN
    chk("lk_c3", rq.req_ready, 4'b0010);
`else
    chk("lk_c3", rq.req_ready, 4'b0001);
`endif
    tick(); #1;
    chk("lk_c4", rq.req_ready, 4'b0010);
    tick();
    rq.req_lock = '0;
    #1;
    chk("lk_c5", rq.req_ready, 4'b0001);
    tick();
    rq.req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/bank_rr_arbiter.md
# bank_rr_arbiter

Round-robin arbiter sharing one physical bank RAM port among NUM_SLOTS requesters, with in-order read-return routing. It sits between the bank masters and the physical RAM. Commands are registered in a single output stage. Every accepted read records its source slot in a tag FIFO, so returned read data is steered back to the slot that issued it, independent of later grants.

## Interface
- NUM_SLOTS, 4: number of requesters, 2..8.
- DATA_W, 64: write/read data width.
- MAX_RD, 4: maximum outstanding reads (tag FIFO depth), power of 2.
- clk in 1: clock.
- rstn in 1: asynchronous active-low reset.
- req_valid in NUM_SLOTS: per-slot command valid.
- req_rw in NUM_SLOTS: 1 = write, 0 = read.
- req_mask in NUM_SLOTS×5: per-slot lane mask.
- req_addr in NUM_SLOTS×9: per-slot word address.
- req_wdata in NUM_SLOTS×DATA_W: write data, valid with the command.
- req_lock in NUM_SLOTS: hold grant (only with BANK_ARB_LOCK_EN).
- req_ready out NUM_SLOTS: command accepted when valid & ready.
- rsp_rvalid out NUM_SLOTS: one-hot read-return strobe.
- rsp_rdata out DATA_W: read data, shared across slots.
- phy_valid out 1: command valid to RAM.
- phy_rw out 1: command direction.
- phy_mask out 5: command lane mask.
- phy_addr out 9: command address.
- phy_wdata out DATA_W: write data.
- phy_ready in 1: RAM accepts the command.
- phy_rvalid in 1: read data returning. Returns arrive in issue order.
- phy_rdata in DATA_W: read data.
- err_orphan out 1: sticky error, set when phy_rvalid arrives with no outstanding tag.

## Operation
- **Pointer.** rr_ptr (log2 NUM_SLOTS bits) gives the highest-priority slot. The search order is rr_ptr, rr_ptr+1, … modulo NUM_SLOTS.
- **Eligibility.** A slot is eligible when req_valid is high. A read is also ineligible when rd_cnt == MAX_RD. The winner is the first eligible slot in search order.
- **Acceptance.** The winner gets req_ready = 1 only when the output register is free, i.e. !phy_valid || phy_ready. All other slots get req_ready = 0.
- **On accept:**
  - The output register loads rw, mask, addr and wdata.
  - phy_valid = 1.
  - rr_ptr = winner + 1 (wraps modulo NUM_SLOTS).
  - If the command is a read, the winner ID is pushed to the tag FIFO.
- **Output register drain.** If phy_valid && phy_ready and nothing is accepted that cycle, phy_valid clears.
- **rd_cnt.** Counts tags held in the FIFO, range 0..MAX_RD.
  - +1 on a read accept.
  - −1 on phy_rvalid while the FIFO is non-empty.
  - Push and pop in the same cycle leave it unchanged.
- **Read return.** On phy_rvalid with a non-empty FIFO, the head tag is popped. rsp_rvalid[tag] = 1 and rsp_rdata = phy_rdata, combinational in the same cycle.
- **Orphan return.** phy_rvalid with an empty FIFO is dropped and sets err_orphan. err_orphan clears only on reset.
- **Ordering.** No RAW reordering: commands issue strictly in acceptance order.

## Timing
- **Reset values:**
  - phy_valid, phy_rw, phy_mask, phy_addr, phy_wdata = 0.
  - rr_ptr = 0, rd_cnt = 0, tag FIFO empty.
  - err_orphan = 0.
  - req_ready and rsp_rvalid are 0 while rstn is low.
- **Command latency.** A command accepted in cycle N appears at phy_valid in cycle N+1. It holds stable until phy_ready.
- **Throughput.** Back-to-back accepts are possible while phy_ready stays high: one command per cycle.
- **Read return latency.** 0 cycles from phy_rvalid to rsp_rvalid.
- **Full tag FIFO.** A read accept and a pop in the same cycle are not both allowed at rd_cnt == MAX_RD. Eligibility uses the registered rd_cnt, so the read waits one cycle.
- **Reset mid-operation.** All tags are lost. A phy_rvalid arriving after reset is counted as an orphan.

## Configuration
- **BANK_ARB_LOCK_EN defined.** If the slot accepted last still asserts req_valid and req_lock, it is the winner regardless of rr_ptr, and rr_ptr is not advanced. Lock still respects the read-outstanding limit.
- **BANK_ARB_LOCK_EN undefined.** req_lock is ignored and the grant is pure round-robin.

## Test plan
- **Round-robin fairness.** All 4 slots hold write requests with phy_ready = 1 → phy_addr order follows slots 0,1,2,3,0; one command per cycle.
- **Backpressure.** phy_ready = 0 for 3 cycles with a command pending → phy_* held constant, all req_ready = 0. phy_ready = 1 → next command in the following cycle.
- **Read routing.** Slot 2 reads addr 0x10, then slot 0 reads addr 0x20. RAM returns 0xAA then 0xBB → rsp_rvalid[2] carries 0xAA, then rsp_rvalid[0] carries 0xBB.
- **Outstanding limit.** MAX_RD = 4 and 5 reads with no return → 4 accepted, 5th req_ready = 0. One phy_rvalid → 5th accepted the next cycle.
- **Orphan.** phy_rvalid with no read issued → no rsp_rvalid, err_orphan = 1 and stays 1 until rstn.
- **Lock (BANK_ARB_LOCK_EN).** Slot 1 holds lock across 3 writes while slot 0 requests → three slot-1 grants, then slot 0. Without the macro, grants alternate.
